// File: rtl/systolic_job_scheduler.sv
// rtl/systolic_job_scheduler.sv - round-robin job intake, job FIFO and sequencer for the shared systolic controller
// Optional S_RUN watchdog is compiled in when SYS_SCHED_TIMEOUT_EN is defined.
module systolic_job_scheduler #(
   parameter int NUM_REQ     = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int TAG_W       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [2*NUM_REQ-1:0]         req_mode,
   input  logic [8*NUM_REQ-1:0]         req_rows,
   input  logic [8*NUM_REQ-1:0]         req_acc_addr,
   input  logic [NUM_REQ-1:0]           req_acc_clear,
   input  logic [TAG_W*NUM_REQ-1:0]     req_tag,
   output logic                         sys_start,
   output logic [1:0]                   sys_mode,
   output logic [7:0]                   sys_rows,
   output logic [7:0]                   sys_acc_addr,
   output logic                         sys_acc_clear,
   input  logic                         sys_busy,
   input  logic                         sys_done,
   output logic                         cpl_valid,
   output logic [$clog2(NUM_REQ)-1:0]   cpl_req_id,
   output logic [TAG_W-1:0]             cpl_tag,
   output logic                         cpl_error,
   output logic                         sched_idle
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = ID_W + TAG_W + 2 + 8 + 8 + 1;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_RUN, S_CPL} state_t;
   state_t state, state_nxt;

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  scan_id;
   logic [NUM_REQ-1:0] grant;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [ENT_W-1:0] push_entry;
   logic [ENT_W-1:0] head;

   logic [ID_W-1:0]  h_id;
   logic [TAG_W-1:0] h_tag;
   logic [1:0]       h_mode;
   logic [7:0]       h_rows;
   logic [7:0]       h_addr;
   logic             h_clear;

   logic             load_sys;
   logic             err_set;
   logic             err_val;
   logic             err_q;
   logic             timeout_hit;

   assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = |grant;
   assign req_ready  = grant;

   // Registered count gates the grant, so a same-cycle pop never frees a slot early
   always_comb begin
      grant    = '0;
      grant_id = '0;
      scan_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!fifo_full && (grant == '0) && req_valid[scan_id]) begin
            grant[scan_id] = 1'b1;
            grant_id       = scan_id;
         end
      end
   end

   always_comb begin
      push_entry = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i])
            push_entry = {ID_W'(i), req_tag[i*TAG_W +: TAG_W], req_mode[i*2 +: 2],
                          req_rows[i*8 +: 8], req_acc_addr[i*8 +: 8], req_acc_clear[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (push)
         rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];
   assign {h_id, h_tag, h_mode, h_rows, h_addr, h_clear} = head;

`ifdef SYS_SCHED_TIMEOUT_EN
   logic [15:0] wd_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wd_cnt <= '0;
      else if (state == S_ISSUE)
         wd_cnt <= '0;
      else if (state == S_RUN)
         wd_cnt <= wd_cnt + 16'd1;
   end

   // wd_cnt reaches TIMEOUT_CYC on the edge that leaves S_RUN
   assign timeout_hit = (state == S_RUN) && (wd_cnt == 16'(TIMEOUT_CYC - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load_sys  = 1'b0;
      err_set   = 1'b0;
      err_val   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty && !sys_busy)
               state_nxt = S_CHECK;
         end
         S_CHECK: begin
            err_set = 1'b1;
            if ((h_rows == 8'd0) || (h_mode == 2'b11)) begin
               err_val   = 1'b1;
               state_nxt = S_CPL;
            end else begin
               load_sys  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = S_RUN;
         S_RUN: begin
            if (sys_done) begin
               err_set   = 1'b1;
               state_nxt = S_CPL;
            end else if (timeout_hit) begin
               err_set   = 1'b1;
               err_val   = 1'b1;
               state_nxt = S_CPL;
            end
         end
         S_CPL: begin
            pop       = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sys_mode      <= '0;
         sys_rows      <= '0;
         sys_acc_addr  <= '0;
         sys_acc_clear <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         if (load_sys) begin
            sys_mode      <= h_mode;
            sys_rows      <= h_rows;
            sys_acc_addr  <= h_addr;
            sys_acc_clear <= h_clear;
         end
         if (err_set)
            err_q <= err_val;
      end
   end

   assign sys_start  = (state == S_ISSUE);
   assign cpl_valid  = (state == S_CPL);
   assign cpl_req_id = cpl_valid ? h_id : '0;
   assign cpl_tag    = cpl_valid ? h_tag : '0;
   assign cpl_error  = cpl_valid & err_q;
   assign sched_idle = fifo_empty && (state == S_IDLE);

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// tb/tb_systolic_job_scheduler.sv - directed self-checking bench for systolic_job_scheduler
module tb_systolic_job_scheduler;

   localparam int NUM_REQ     = 2;
   localparam int FIFO_DEPTH  = 4;
   localparam int TAG_W       = 4;
   localparam int TIMEOUT_CYC = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_mode;
   logic [15:0] req_rows;
   logic [15:0] req_acc_addr;
   logic [1:0]  req_acc_clear;
   logic [7:0]  req_tag;
   logic        sys_start;
   logic [1:0]  sys_mode;
   logic [7:0]  sys_rows;
   logic [7:0]  sys_acc_addr;
   logic        sys_acc_clear;
   logic        sys_busy;
   logic        sys_done;
   logic        model_done;
   logic        tb_done;
   logic        cpl_valid;
   logic        cpl_req_id;
   logic [3:0]  cpl_tag;
   logic        cpl_error;
   logic        sched_idle;

   assign sys_done = model_done | tb_done;

   systolic_job_scheduler #(
      .NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_rows(req_rows),
      .req_acc_addr(req_acc_addr), .req_acc_clear(req_acc_clear), .req_tag(req_tag),
      .sys_start(sys_start), .sys_mode(sys_mode), .sys_rows(sys_rows),
      .sys_acc_addr(sys_acc_addr), .sys_acc_clear(sys_acc_clear),
      .sys_busy(sys_busy), .sys_done(sys_done),
      .cpl_valid(cpl_valid), .cpl_req_id(cpl_req_id), .cpl_tag(cpl_tag),
      .cpl_error(cpl_error), .sched_idle(sched_idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [1:0] mode;
      logic [7:0] rows;
      logic [7:0] addr;
      logic       clr;
   } start_t;

   typedef struct {
      int         c;
      logic       id;
      logic [3:0] tag;
      logic       err;
   } cpl_t;

   start_t start_q[$];
   cpl_t   cpl_q[$];

   always @(negedge clk) begin
      if (rst_n && sys_start)
         start_q.push_back('{cyc, sys_mode, sys_rows, sys_acc_addr, sys_acc_clear});
      if (rst_n && cpl_valid)
         cpl_q.push_back('{cyc, cpl_req_id, cpl_tag, cpl_error});
   end

   // Systolic controller model: done pulse done_delay cycles after sys_start (0 = never)
   int done_delay = 0;
   initial begin
      model_done = 1'b0;
      forever begin
         @(negedge clk);
         if (sys_start && done_delay > 0) begin
            repeat (done_delay) @(posedge clk);
            #1 model_done = 1'b1;
            @(posedge clk);
            #1 model_done = 1'b0;
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic reset_dut();
      rst_n         = 1'b0;
      req_valid     = '0;
      req_mode      = '0;
      req_rows      = '0;
      req_acc_addr  = '0;
      req_acc_clear = '0;
      req_tag       = '0;
      sys_busy      = 1'b0;
      tb_done       = 1'b0;
      done_delay    = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that follows the handshake
   task automatic send(input int id, input logic [1:0] mode, input logic [7:0] rows,
                       input logic [7:0] addr, input logic clr, input logic [3:0] tag,
                       output int hs);
      req_valid[id]        = 1'b1;
      req_mode[id*2 +: 2]  = mode;
      req_rows[id*8 +: 8]  = rows;
      req_acc_addr[id*8 +: 8] = addr;
      req_acc_clear[id]    = clr;
      req_tag[id*4 +: 4]   = tag;
      hs = -1;
      for (int i = 0; i < 100 && hs < 0; i++) begin
         @(negedge clk);
         if (req_ready[id]) hs = cyc;
      end
      check("send_handshake", 32'(hs >= 0), 1);
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
   endtask

   task automatic wait_cpl(input int n, input int budget);
      for (int i = 0; i < budget && cpl_q.size() < n; i++) @(negedge clk);
      check("cpl_count", cpl_q.size(), n);
   endtask

   int gid[$];
   int gcyc[$];

   initial begin
      int     hs;
      int     hs_a;
      int     s0;
      int     c0;
      int     f;
      logic [1:0] g;
      start_t st;
      cpl_t   cp;

      // Reset state
      reset_dut();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_sys_start", 32'(sys_start), 0);
      check("rst_sys_mode", 32'(sys_mode), 0);
      check("rst_sys_rows", 32'(sys_rows), 0);
      check("rst_sys_addr", 32'(sys_acc_addr), 0);
      check("rst_sys_clear", 32'(sys_acc_clear), 0);
      check("rst_cpl_valid", 32'(cpl_valid), 0);
      check("rst_cpl_id", 32'(cpl_req_id), 0);
      check("rst_cpl_tag", 32'(cpl_tag), 0);
      check("rst_cpl_error", 32'(cpl_error), 0);
      check("rst_sched_idle", 32'(sched_idle), 1);

      // Single job
      @(posedge clk); #1;
      done_delay = 12;
      s0 = start_q.size();
      c0 = cpl_q.size();
      send(0, 2'b00, 8'd3, 8'h10, 1'b1, 4'd5, hs);
      check("t1_busy_idle", 32'(sched_idle), 0);
      wait_cpl(c0 + 1, 100);
      @(posedge clk); #1;
      check("t1_starts", start_q.size(), s0 + 1);
      if (start_q.size() > s0 && cpl_q.size() > c0) begin
         st = start_q[s0];
         cp = cpl_q[c0];
         check("t1_start_cyc", st.c, hs + 3);
         check("t1_mode", 32'(st.mode), 0);
         check("t1_rows", 32'(st.rows), 3);
         check("t1_addr", 32'(st.addr), 32'h10);
         check("t1_clear", 32'(st.clr), 1);
         check("t1_cpl_cyc", cp.c, st.c + 13);
         check("t1_cpl_id", 32'(cp.id), 0);
         check("t1_cpl_tag", 32'(cp.tag), 5);
         check("t1_cpl_err", 32'(cp.err), 0);
      end
      check("t1_idle_after", 32'(sched_idle), 1);
      check("t1_rows_hold", 32'(sys_rows), 3);

      // Fairness and FIFO full backpressure
      reset_dut();
      done_delay = 5;
      c0 = cpl_q.size();
      req_rows  = {8'd1, 8'd1};
      req_mode  = '0;
      req_tag   = {4'd8, 4'd0};
      req_valid = 2'b11;
      for (int i = 0; i < 300 && gid.size() < 6; i++) begin
         @(negedge clk);
         g = req_ready;
         if (g[0]) begin gid.push_back(0); gcyc.push_back(cyc); end
         if (g[1]) begin gid.push_back(1); gcyc.push_back(cyc); end
         @(posedge clk); #1;
         if (g[0]) req_tag[3:0] = req_tag[3:0] + 4'd1;
         if (g[1]) req_tag[7:4] = req_tag[7:4] + 4'd1;
         if (gid.size() >= 6) req_valid = '0;
      end
      check("t2_grants", gid.size(), 6);
      wait_cpl(c0 + 6, 200);
      if (gid.size() == 6 && cpl_q.size() >= c0 + 6) begin
         for (int k = 0; k < 6; k++) begin
            check("t2_grant_id", gid[k], k % 2);
            check("t2_cpl_id", 32'(cpl_q[c0+k].id), k % 2);
            check("t2_cpl_tag", 32'(cpl_q[c0+k].tag), (k % 2 == 0) ? k / 2 : 8 + k / 2);
            check("t2_cpl_err", 32'(cpl_q[c0+k].err), 0);
         end
         check("t2_fill_cycles", gcyc[3] - gcyc[0], 3);
         check("t2_full_release", gcyc[4], cpl_q[c0].c + 1);
      end

      // Illegal jobs: rows==0, then mode==11
      reset_dut();
      done_delay = 5;
      s0 = start_q.size();
      c0 = cpl_q.size();
      send(0, 2'b00, 8'd0, 8'h20, 1'b0, 4'd2, hs);
      hs_a = hs;
      send(0, 2'b11, 8'd4, 8'h30, 1'b0, 4'd3, hs);
      wait_cpl(c0 + 2, 100);
      repeat (5) @(posedge clk);
      #1;
      check("t3_no_start", start_q.size(), s0);
      if (cpl_q.size() >= c0 + 2) begin
         check("t3_tag0", 32'(cpl_q[c0].tag), 2);
         check("t3_err0", 32'(cpl_q[c0].err), 1);
         check("t3_tag1", 32'(cpl_q[c0+1].tag), 3);
         check("t3_err1", 32'(cpl_q[c0+1].err), 1);
         check("t3_cpl0_cyc", cpl_q[c0].c, hs_a + 3);
         check("t3_cpl1_cyc", cpl_q[c0+1].c, cpl_q[c0].c + 3);
      end

      // Busy interlock
      reset_dut();
      done_delay = 4;
      sys_busy = 1'b1;
      s0 = start_q.size();
      c0 = cpl_q.size();
      send(1, 2'b01, 8'd2, 8'h40, 1'b0, 4'd7, hs);
      repeat (20) @(posedge clk);
      #1;
      check("t4_no_start_busy", start_q.size(), s0);
      sys_busy = 1'b0;
      f = cyc;
      wait_cpl(c0 + 1, 100);
      if (start_q.size() > s0 && cpl_q.size() > c0) begin
         check("t4_start_cyc", start_q[s0].c, f + 2);
         check("t4_mode", 32'(start_q[s0].mode), 1);
         check("t4_cpl_id", 32'(cpl_q[c0].id), 1);
         check("t4_cpl_tag", 32'(cpl_q[c0].tag), 7);
         check("t4_cpl_err", 32'(cpl_q[c0].err), 0);
      end

      // Reset while a job runs with two more queued
      reset_dut();
      done_delay = 0;
      s0 = start_q.size();
      c0 = cpl_q.size();
      send(0, 2'b00, 8'd1, 8'h50, 1'b0, 4'd1, hs);
      send(0, 2'b00, 8'd1, 8'h51, 1'b0, 4'd2, hs);
      send(0, 2'b00, 8'd1, 8'h52, 1'b0, 4'd3, hs);
      for (int i = 0; i < 50 && start_q.size() <= s0; i++) @(negedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t5_pre_idle", 32'(sched_idle), 0);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_sys_start", 32'(sys_start), 0);
      check("t5_rst_sys_rows", 32'(sys_rows), 0);
      check("t5_rst_sys_addr", 32'(sys_acc_addr), 0);
      check("t5_rst_cpl_valid", 32'(cpl_valid), 0);
      check("t5_rst_idle", 32'(sched_idle), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tb_done = 1'b1;
      @(posedge clk);
      #1 tb_done = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("t5_no_cpl", cpl_q.size(), c0);
      check("t5_no_reissue", start_q.size(), s0 + 1);
      check("t5_idle", 32'(sched_idle), 1);

`ifdef SYS_SCHED_TIMEOUT_EN
      // Watchdog expiry then normal follow-on job
      reset_dut();
      done_delay = 0;
      s0 = start_q.size();
      c0 = cpl_q.size();
      send(0, 2'b00, 8'd2, 8'h60, 1'b0, 4'd1, hs);
      send(1, 2'b00, 8'd3, 8'h70, 1'b0, 4'd2, hs);
      wait_cpl(c0 + 1, 100);
      done_delay = 4;
      if (start_q.size() > s0 && cpl_q.size() > c0) begin
         check("t6_timeout_cyc", cpl_q[c0].c, start_q[s0].c + 21);
         check("t6_timeout_err", 32'(cpl_q[c0].err), 1);
         check("t6_timeout_tag", 32'(cpl_q[c0].tag), 1);
      end
      wait_cpl(c0 + 2, 100);
      check("t6_second_start", start_q.size(), s0 + 2);
      if (start_q.size() > s0 + 1 && cpl_q.size() > c0 + 1) begin
         check("t6_second_rows", 32'(start_q[s0+1].rows), 3);
         check("t6_second_err", 32'(cpl_q[c0+1].err), 0);
         check("t6_second_tag", 32'(cpl_q[c0+1].tag), 2);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1, "global timeout");
   end

endmodule
